fp_operator_arbiter: RTL and testbench
======================================

Name: fp_operator_arbiter

Overview:
- Shares one floating-point operator wrapper (adder, subtractor, multiplier or divider; 32-bit IEEE-754 single) between NREQ requesters inside kalmanalu, so each Kalman equation stage does not need its own operator instance.
- Performs round-robin arbitration and drives a registered issue stage toward the operator.
- Tracks in-order outstanding operations in a tag FIFO and routes each operator result back to the requester that issued it.
- The operator wrapper is treated as opaque, returns results in order, and may apply backpressure.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DEPTH, 8, maximum outstanding operations, i.e. tag FIFO entries (power of two, >= operator latency + 2 for full throughput).
- TAGW, 2, tag width; must equal clog2(NREQ).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; combinational; at most one bit high.
- req_dataa  in  NREQ*32  operand A, requester i at bits [32i+31:32i].
- req_datab  in  NREQ*32  operand B, same packing.
- op_valid  out  1  issue valid toward the operator.
- op_ready  in  1  operator accepts the issue.
- op_dataa  out  32  issued operand A.
- op_datab  out  32  issued operand B.
- op_result_valid  in  1  operator result strobe.
- op_result  in  32  operator result.
- rsp_valid  out  NREQ  one-hot result strobe, one cycle.
- rsp_result  out  32  result, valid while any rsp_valid bit is high.
- outstanding  out  clog2(DEPTH)+1  current tag FIFO occupancy.
- err_orphan  out  1  sticky: result arrived with tag FIFO empty.

Behaviour:
- Reset (reset=0, async): op_valid=0, op_dataa/op_datab=0, rsp_valid=0, rsp_result=0, outstanding=0, err_orphan=0, RR pointer=0, FIFO emptied. Reset mid-operation drops all in-flight tags. The operator wrapper must share the same reset; any result arriving after reset sets err_orphan.
- Slot available (slot_ok): (op_valid==0 or op_ready==1) and (outstanding < DEPTH or a pop occurs this cycle).
- Arbitration (combinational): the winner is the first i with req_valid[i]=1, searching from RR pointer upward with wrap modulo NREQ. req_ready[winner]=slot_ok; all other bits 0. No combinational path from op_result_valid to req_ready except through the pop term.
- Accept (req_valid[i] & req_ready[i]):
  - next cycle: op_valid=1, op_dataa/op_datab = requester i operands;
  - tag i pushed to the FIFO in the same cycle;
  - RR pointer <= i+1 mod NREQ.
- Issue hold: while op_valid=1 and op_ready=0, op_valid/op_dataa/op_datab stay stable. On op_ready=1 with no new accept, op_valid<=0.
- Throughput: one accept per cycle when op_ready stays high and the FIFO is not full. Accept-to-op_valid latency is 1 cycle.
- Result: op_result_valid=1 with FIFO non-empty pops the head tag t. Next cycle, rsp_valid=onehot(t) and rsp_result=op_result. Result-to-response latency is 1 cycle.
- Orphan: op_result_valid=1 with FIFO empty sets err_orphan (cleared only by reset). No rsp_valid is produced and outstanding is unchanged.
- Simultaneous push and pop: occupancy unchanged; a pop frees an entry for a same-cycle push when full.
- Full (outstanding==DEPTH, no pop): all req_ready=0; issue stage continues draining.
- Pointer wrap: FIFO read/write pointers carry one extra bit; full/empty are derived from MSB compare.
- op_result_valid is ignored for routing when the FIFO is empty; only err_orphan is affected.

Test Plan:
- Reset, then req 0 with req_valid[0]=1, dataa=0x40066666, datab=0x4059999a -> req_ready[0]=1 that cycle; next cycle op_valid=1 and op_dataa/op_datab match; bench operator (latency 4) returns 0x40e47ae1 -> rsp_valid=4'b0001, rsp_result=0x40e47ae1; outstanding returns to 0.
- All four requesters valid continuously, op_ready=1 -> grants in order 0,1,2,3,0,...; responses one-hot in the same order; no requester starved.
- op_ready held 0 for 10 cycles with requester 2 valid (dataa=0x3f0a3d71) -> op_valid/op_dataa stable for all 10 cycles; exactly one accept before the stall and none during it once the issue slot is occupied.
- Operator never returns results, continuous requests -> outstanding climbs to 8 and all req_ready=0; one op_result_valid then gives one pop and one new accept in the same cycle, with outstanding staying at 8.
- op_result_valid=1 immediately after reset -> err_orphan=1 and stays 1; rsp_valid stays 0.
- Assert reset with 3 outstanding -> all outputs go to reset values asynchronously; after release, a new request from requester 3 is granted first (pointer=0, requesters 0..2 idle).

Source files
------------

// File: rtl/fp_operator_arbiter.sv
// fp_operator_arbiter
//
// Shares one opaque, in-order floating-point operator (add/sub/mul/div,
// IEEE-754 single) between NREQ requesters. A round-robin arbiter picks one
// requester per cycle and loads a registered issue stage. The requester index
// of every accepted operation is pushed into a tag FIFO. Results come back
// in order, so each result pops the head tag and is routed to that requester.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous, active-low reset
//   req_valid        per-requester operand valid
//   req_ready        per-requester accept (combinational, at most one bit high)
//   req_dataa/datab  packed operands, requester i at [32i+31:32i]
//   op_valid         issue valid toward the operator
//   op_ready         operator accepts the issue
//   op_dataa/datab   issued operands
//   op_result_valid  operator result strobe
//   op_result        operator result
//   rsp_valid        one-hot, one-cycle result strobe back to the requester
//   rsp_result       result, valid while any rsp_valid bit is high
//   outstanding      tag FIFO occupancy
//   err_orphan       sticky: a result arrived while no operation was pending
module fp_operator_arbiter #(
   parameter int NREQ  = 4,
   parameter int DEPTH = 8,
   parameter int TAGW  = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*32-1:0]      req_dataa,
   input  logic [NREQ*32-1:0]      req_datab,
   output logic                    op_valid,
   input  logic                    op_ready,
   output logic [31:0]             op_dataa,
   output logic [31:0]             op_datab,
   input  logic                    op_result_valid,
   input  logic [31:0]             op_result,
   output logic [NREQ-1:0]         rsp_valid,
   output logic [31:0]             rsp_result,
   output logic [$clog2(DEPTH):0]  outstanding,
   output logic                    err_orphan
);

   localparam int AW = $clog2(DEPTH);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [TAGW-1:0]  rr_ptr_reg;
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [TAGW-1:0]  tag_mem [DEPTH];
   logic             op_valid_reg;
   logic [31:0]      op_dataa_reg;
   logic [31:0]      op_datab_reg;
   logic [NREQ-1:0]  rsp_valid_reg;
   logic [31:0]      rsp_result_reg;
   logic             err_orphan_reg;

   // ------------------------------------------------------------------
   // Operand unpacking and head-tag decode
   // ------------------------------------------------------------------
   logic [31:0]      dataa_arr [NREQ];
   logic [31:0]      datab_arr [NREQ];
   logic [TAGW-1:0]  head_tag;
   logic [NREQ-1:0]  head_onehot;

   assign head_tag = tag_mem[rd_ptr_reg[AW-1:0]];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign dataa_arr[gi]   = req_dataa[32*gi +: 32];
      assign datab_arr[gi]   = req_datab[32*gi +: 32];
      assign head_onehot[gi] = (head_tag == TAGW'(gi));
   end

   // ------------------------------------------------------------------
   // FIFO status. Pointers carry one extra wrap bit: equal pointers mean
   // empty, equal index with differing wrap bits means full.
   // ------------------------------------------------------------------
   logic fifo_empty;
   logic fifo_full;
   logic pop;
   logic slot_ok;

   assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign outstanding = wr_ptr_reg - rd_ptr_reg;

   // The only path from op_result_valid to req_ready is this pop term,
   // which lets a full FIFO accept a new operation in the cycle it drains one.
   assign pop     = op_result_valid & ~fifo_empty;
   assign slot_ok = (~op_valid_reg | op_ready) & (~fifo_full | pop);

   // ------------------------------------------------------------------
   // Round-robin arbitration: scan from rr_ptr upward with wrap. The scan
   // runs from the farthest offset down so the nearest valid requester is
   // the last one written and therefore wins.
   // ------------------------------------------------------------------
   logic             any_valid;
   logic [TAGW-1:0]  winner;
   logic             accept;

   always_comb begin
      int              idx;
      logic [TAGW-1:0] idx_t;
      any_valid = 1'b0;
      winner    = '0;
      idx       = 0;
      idx_t     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_reg) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         idx_t = TAGW'(idx);
         if (req_valid[idx_t]) begin
            any_valid = 1'b1;
            winner    = idx_t;
         end
      end
   end

   assign accept = any_valid & slot_ok;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = accept & (winner == TAGW'(gi));
   end

   // ------------------------------------------------------------------
   // Issue stage, round-robin pointer and FIFO pointers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_valid_reg <= 1'b0;
         op_dataa_reg <= '0;
         op_datab_reg <= '0;
         rr_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
      end else begin
         if (accept) begin
            op_valid_reg <= 1'b1;
            op_dataa_reg <= dataa_arr[winner];
            op_datab_reg <= datab_arr[winner];
            rr_ptr_reg   <= (winner == TAGW'(NREQ - 1)) ? '0 : winner + 1'b1;
            wr_ptr_reg   <= wr_ptr_reg + 1'b1;
         end else if (op_ready) begin
            // Issue handed over and nothing new to send: drop valid but keep
            // the operands, they are don't-care while op_valid is low.
            op_valid_reg <= 1'b0;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   // Tag storage has no reset: entries are only read between push and pop.
   // On a full-FIFO push+pop the write hits the head slot, whose old value
   // is read combinationally in the same cycle, so no bypass is needed.
   always_ff @(posedge clock) begin
      if (accept) begin
         tag_mem[wr_ptr_reg[AW-1:0]] <= winner;
      end
   end

   // ------------------------------------------------------------------
   // Response routing and orphan detection
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rsp_valid_reg  <= '0;
         rsp_result_reg <= '0;
         err_orphan_reg <= 1'b0;
      end else begin
         if (pop) begin
            rsp_valid_reg  <= head_onehot;
            rsp_result_reg <= op_result;
         end else begin
            rsp_valid_reg  <= '0;
         end
         if (op_result_valid & fifo_empty) begin
            err_orphan_reg <= 1'b1;
         end
      end
   end

   assign op_valid   = op_valid_reg;
   assign op_dataa   = op_dataa_reg;
   assign op_datab   = op_datab_reg;
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_result = rsp_result_reg;
   assign err_orphan = err_orphan_reg;

endmodule

// File: tb/tb_fp_operator_arbiter.sv
// Testbench for fp_operator_arbiter: a behavioural in-order operator with
// fixed latency sits on the issue side, expected responses are queued when a
// requester is accepted and compared when the DUT routes a result back.
module tb_fp_operator_arbiter;

   localparam int NREQ  = 4;
   localparam int DEPTH = 8;
   localparam int TAGW  = 2;
   localparam int LAT   = 4;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*32-1:0]  req_dataa = '0;
   logic [NREQ*32-1:0]  req_datab = '0;
   logic                op_valid;
   logic                op_ready = 1'b1;
   logic [31:0]         op_dataa;
   logic [31:0]         op_datab;
   logic                op_result_valid = 1'b0;
   logic [31:0]         op_result = '0;
   logic [NREQ-1:0]     rsp_valid;
   logic [31:0]         rsp_result;
   logic [3:0]          outstanding;
   logic                err_orphan;

   fp_operator_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
      .clock           (clock),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_dataa       (req_dataa),
      .req_datab       (req_datab),
      .op_valid        (op_valid),
      .op_ready        (op_ready),
      .op_dataa        (op_dataa),
      .op_datab        (op_datab),
      .op_result_valid (op_result_valid),
      .op_result       (op_result),
      .rsp_valid       (rsp_valid),
      .rsp_result      (rsp_result),
      .outstanding     (outstanding),
      .err_orphan      (err_orphan)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [TAGW-1:0] tag;
      logic [31:0]     res;
   } sb_t;

   typedef struct {
      logic [31:0] res;
      int          due;
   } op_t;

   sb_t   sb_q[$];
   op_t   pipe_q[$];
   int    grant_q[$];

   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   int    model_out = 0;
   int    rr_m     = 0;
   int    dut_acc  = 0;
   int    rsp_count = 0;
   logic  exp_op_valid = 1'b0;
   logic  [31:0] exp_a = '0;
   logic  [31:0] exp_b = '0;
   logic  exp_err = 1'b0;
   logic  op_enable = 1'b1;
   logic  force_orphan = 1'b0;
   logic  [NREQ-1:0] last_rsp_valid = '0;
   logic  [31:0]     last_rsp_result = '0;

   // Bench operator function: the known multiply pair from the test plan,
   // otherwise an arbitrary but deterministic mix of both operands.
   function automatic logic [31:0] fop(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40066666 && b == 32'h4059999a) return 32'h40e47ae1;
      return a ^ {b[15:0], b[31:16]} ^ 32'h0000a5a5;
   endfunction

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
      req_dataa[32*i +: 32] = a;
      req_datab[32*i +: 32] = b;
   endtask

   // One clock cycle: present operator result, check arbitration, model the
   // issue stage and FIFO, then check registered outputs after the edge.
   task automatic step();
      logic            pop_m;
      logic            slot_m;
      logic            found;
      int              w;
      logic [NREQ-1:0] exp_ready;
      logic            exp_rsp;
      sb_t             e;
      logic [31:0]     ra;
      logic [31:0]     rb;
      if (force_orphan) begin
         op_result_valid = 1'b1;
         op_result       = 32'h7fc00000;
      end else if (op_enable && pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
         op_result_valid = 1'b1;
         op_result       = pipe_q[0].res;
         void'(pipe_q.pop_front());
      end else begin
         op_result_valid = 1'b0;
         op_result       = '0;
      end
      #1;
      pop_m  = op_result_valid && (model_out > 0);
      slot_m = (!exp_op_valid || op_ready) && ((model_out < DEPTH) || pop_m);
      found  = 1'b0;
      w      = 0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (rr_m + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            w     = idx;
         end
      end
      exp_ready = (found && slot_m) ? (NREQ'(1) << w) : '0;
      n_checks++;
      if (req_ready !== exp_ready) begin
         n_fail++;
         $display("FAIL req_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready);
      end
      n_checks++;
      if (outstanding !== 4'(model_out)) begin
         n_fail++;
         $display("FAIL outstanding cyc=%0d got=%0d want=%0d", cyc, outstanding, model_out);
      end
      for (int k = 0; k < NREQ; k++) begin
         if (req_valid[k] && req_ready[k]) begin
            dut_acc++;
            grant_q.push_back(k);
            $display("grant req=%0d a=%h b=%h", k, req_dataa[32*k +: 32], req_datab[32*k +: 32]);
         end
      end
      exp_rsp = pop_m;
      if (op_result_valid && model_out == 0) exp_err = 1'b1;
      if (pop_m) model_out--;
      if (op_valid && op_ready) pipe_q.push_back('{fop(op_dataa, op_datab), cyc + LAT});
      if (found && slot_m) begin
         ra = req_dataa[32*w +: 32];
         rb = req_datab[32*w +: 32];
         sb_q.push_back('{TAGW'(w), fop(ra, rb)});
         model_out++;
         rr_m = (w + 1) % NREQ;
         exp_op_valid = 1'b1;
         exp_a = ra;
         exp_b = rb;
      end else if (op_ready) begin
         exp_op_valid = 1'b0;
      end
      @(posedge clock);
      cyc++;
      #1;
      n_checks++;
      if (op_valid !== exp_op_valid) begin
         n_fail++;
         $display("FAIL op_valid cyc=%0d got=%b want=%b", cyc, op_valid, exp_op_valid);
      end
      if (exp_op_valid) begin
         n_checks++;
         if (op_dataa !== exp_a || op_datab !== exp_b) begin
            n_fail++;
            $display("FAIL op_data cyc=%0d got=%h/%h want=%h/%h", cyc, op_dataa, op_datab, exp_a, exp_b);
         end
      end
      n_checks++;
      if (err_orphan !== exp_err) begin
         n_fail++;
         $display("FAIL err_orphan cyc=%0d got=%b want=%b", cyc, err_orphan, exp_err);
      end
      if (exp_rsp && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_checks++;
         if (rsp_valid !== (NREQ'(1) << e.tag) || rsp_result !== e.res) begin
            n_fail++;
            $display("FAIL response cyc=%0d got=%b/%h want=%b/%h", cyc, rsp_valid, rsp_result,
                     NREQ'(1) << e.tag, e.res);
         end
         last_rsp_valid  = rsp_valid;
         last_rsp_result = rsp_result;
         rsp_count++;
         $display("rsp req=%0d result=%h", e.tag, rsp_result);
      end else begin
         n_checks++;
         if (rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL rsp_idle cyc=%0d got=%b want=0", cyc, rsp_valid);
         end
      end
      @(negedge clock);
   endtask

   task automatic drain();
      int guard;
      guard     = 0;
      req_valid = '0;
      op_ready  = 1'b1;
      op_enable = 1'b1;
      while ((model_out > 0 || exp_op_valid || pipe_q.size() > 0) && guard < 100) begin
         step();
         guard++;
      end
      n_checks++;
      if (outstanding !== 4'd0 || model_out != 0) begin
         n_fail++;
         $display("FAIL drain outstanding=%0d want=0 after %0d cycles", outstanding, guard);
      end
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      #2;
      n_checks++;
      if (op_valid !== 1'b0 || rsp_valid !== '0 || outstanding !== 4'd0 ||
          err_orphan !== 1'b0 || op_dataa !== '0 || op_datab !== '0 || rsp_result !== '0) begin
         n_fail++;
         $display("FAIL reset_state got v=%b rsp=%b out=%0d err=%b want all zero",
                  op_valid, rsp_valid, outstanding, err_orphan);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_orphan();
      force_orphan = 1'b1;
      step();
      force_orphan = 1'b0;
      n_checks++;
      if (err_orphan !== 1'b1 || rsp_valid !== '0) begin
         n_fail++;
         $display("FAIL orphan got err=%b rsp=%b want err=1 rsp=0", err_orphan, rsp_valid);
      end
      step();
      step();
      n_checks++;
      if (err_orphan !== 1'b1 || outstanding !== 4'd0) begin
         n_fail++;
         $display("FAIL orphan_sticky got err=%b out=%0d want 1/0", err_orphan, outstanding);
      end
   endtask

   task automatic test_single();
      int r0;
      int waits;
      set_req(0, 32'h40066666, 32'h4059999a);
      req_valid = 4'b0001;
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL single_ready got=%b want=0001", req_ready);
      end
      r0 = rsp_count;
      step();
      req_valid = '0;
      n_checks++;
      if (op_valid !== 1'b1 || op_dataa !== 32'h40066666 || op_datab !== 32'h4059999a) begin
         n_fail++;
         $display("FAIL single_issue got=%b %h %h want 1 40066666 4059999a", op_valid, op_dataa, op_datab);
      end
      waits = 0;
      while (rsp_count == r0 && waits < 20) begin
         step();
         waits++;
      end
      n_checks++;
      if (last_rsp_valid !== 4'b0001 || last_rsp_result !== 32'h40e47ae1 || waits != LAT + 1) begin
         n_fail++;
         $display("FAIL single_rsp got=%b %h after %0d want 0001 40e47ae1 after %0d",
                  last_rsp_valid, last_rsp_result, waits, LAT + 1);
      end
      drain();
   endtask

   task automatic test_round_robin();
      int start;
      for (int i = 0; i < NREQ; i++) set_req(i, 32'h3f800000 + i, 32'h40000000 + 7 * i);
      grant_q.delete();
      start     = rr_m;
      req_valid = 4'b1111;
      op_ready  = 1'b1;
      op_enable = 1'b1;
      for (int n = 0; n < 16; n++) step();
      n_checks++;
      if (grant_q.size() != 16) begin
         n_fail++;
         $display("FAIL rr_count got=%0d want=16", grant_q.size());
      end
      for (int k = 0; k < grant_q.size(); k++) begin
         n_checks++;
         if (grant_q[k] != (start + k) % NREQ) begin
            n_fail++;
            $display("FAIL rr_order k=%0d got=%0d want=%0d", k, grant_q[k], (start + k) % NREQ);
         end
      end
      drain();
   endtask

   task automatic test_stall();
      int a0;
      set_req(2, 32'h3f0a3d71, 32'h3f19999a);
      req_valid = 4'b0100;
      op_ready  = 1'b0;
      a0 = dut_acc;
      for (int n = 0; n < 10; n++) begin
         step();
         n_checks++;
         if (op_valid !== 1'b1 || op_dataa !== 32'h3f0a3d71) begin
            n_fail++;
            $display("FAIL stall_hold n=%0d got=%b %h want 1 3f0a3d71", n, op_valid, op_dataa);
         end
      end
      n_checks++;
      if (dut_acc - a0 != 1) begin
         n_fail++;
         $display("FAIL stall_accepts got=%0d want=1", dut_acc - a0);
      end
      drain();
   endtask

   task automatic test_full();
      int guard;
      int a0;
      int r0;
      for (int i = 0; i < NREQ; i++) set_req(i, 32'h41200000 + 32'h100 * i, 32'hc0000000 + i);
      op_enable = 1'b0;
      op_ready  = 1'b1;
      req_valid = 4'b1111;
      guard = 0;
      while (outstanding != 4'd8 && guard < 20) begin
         step();
         guard++;
      end
      step();
      #1;
      n_checks++;
      if (outstanding !== 4'd8 || req_ready !== '0) begin
         n_fail++;
         $display("FAIL full_state got out=%0d ready=%b want 8/0000", outstanding, req_ready);
      end
      a0 = dut_acc;
      r0 = rsp_count;
      op_enable = 1'b1;
      step();
      op_enable = 1'b0;
      n_checks++;
      if (dut_acc - a0 != 1 || rsp_count - r0 != 1 || outstanding !== 4'd8) begin
         n_fail++;
         $display("FAIL full_pop_push got acc=%0d rsp=%0d out=%0d want 1/1/8",
                  dut_acc - a0, rsp_count - r0, outstanding);
      end
      drain();
   endtask

   task automatic test_reset_midop();
      op_enable = 1'b0;
      op_ready  = 1'b1;
      set_req(2, 32'h3e800000, 32'h3f400000);
      req_valid = 4'b0100;
      for (int n = 0; n < 3; n++) step();
      req_valid = '0;
      n_checks++;
      if (outstanding !== 4'd3) begin
         n_fail++;
         $display("FAIL midop_pending got=%0d want=3", outstanding);
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (op_valid !== 1'b0 || rsp_valid !== '0 || outstanding !== 4'd0 ||
          err_orphan !== 1'b0 || op_dataa !== '0 || op_datab !== '0 || rsp_result !== '0) begin
         n_fail++;
         $display("FAIL async_reset got v=%b rsp=%b out=%0d err=%b want all zero",
                  op_valid, rsp_valid, outstanding, err_orphan);
      end
      sb_q.delete();
      pipe_q.delete();
      model_out    = 0;
      rr_m         = 0;
      exp_op_valid = 1'b0;
      exp_a        = '0;
      exp_b        = '0;
      exp_err      = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      set_req(1, 32'h3f800000, 32'h3f800000);
      set_req(3, 32'h40400000, 32'h40800000);
      req_valid = 4'b1010;
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL rr_after_reset got=%b want=0010", req_ready);
      end
      req_valid = 4'b1000;
      #1;
      n_checks++;
      if (req_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL req3_first got=%b want=1000", req_ready);
      end
      op_enable = 1'b1;
      step();
      drain();
   endtask

   initial begin
      test_reset();
      test_orphan();
      test_single();
      test_round_robin();
      test_stall();
      test_full();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout reached without completing");
      $fatal(1, "timeout");
   end

endmodule
